id_ex_stage: RTL and testbench



---
 rtl/id_ex_stage.sv | 88 ++++++++
 tb/tb_id_ex_stage.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with load-use hazard detection (optional ID_EX_PERF_EN bubble counter)
module id_ex_stage #(
    parameter int CTRL_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [31:0]       id_pc,
    input  logic [31:0]       id_rdata1,
    input  logic [31:0]       id_rdata2,
    input  logic [31:0]       id_imm,
    input  logic [4:0]        id_rs,
    input  logic [4:0]        id_rt,
    input  logic [4:0]        id_rd,
    input  logic              id_uses_rt,
    input  logic              id_memread,
    input  logic              id_regwrite,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic              flush,
    input  logic              ex_hold,
    output logic              ex_valid,
    output logic              ex_memread,
    output logic              ex_regwrite,
    output logic [31:0]       ex_pc,
    output logic [31:0]       ex_rdata1,
    output logic [31:0]       ex_rdata2,
    output logic [31:0]       ex_imm,
    output logic [4:0]        ex_rs,
    output logic [4:0]        ex_rt,
    output logic [4:0]        ex_rd,
    output logic [CTRL_W-1:0] ex_ctrl,
`ifdef ID_EX_PERF_EN
    output logic [31:0]       stall_cnt,
`endif
    output logic              stall_if_id
);

    logic load_use;
    logic load_bubble;

    // A load writing $zero never produces a usable value, so it cannot create a hazard.
    always_comb begin
        load_use = ex_valid & ex_memread & (ex_rt != 5'd0) & id_valid &
                   ((id_rs == ex_rt) | (id_uses_rt & (id_rt == ex_rt)));
    end

    assign stall_if_id = rst & (ex_hold | (load_use & ~flush));
    assign load_bubble = ~rst | flush | (~ex_hold & load_use);

    always_ff @(posedge clk) begin
        if (load_bubble) begin
            ex_valid    <= 1'b0;
            ex_memread  <= 1'b0;
            ex_regwrite <= 1'b0;
            ex_pc       <= 32'd0;
            ex_rdata1   <= 32'd0;
            ex_rdata2   <= 32'd0;
            ex_imm      <= 32'd0;
            ex_rs       <= 5'd0;
            ex_rt       <= 5'd0;
            ex_rd       <= 5'd0;
            ex_ctrl     <= '0;
        end else if (!ex_hold) begin
            ex_valid    <= id_valid;
            ex_memread  <= id_valid & id_memread;
            ex_regwrite <= id_valid & id_regwrite;
            ex_pc       <= id_pc;
            ex_rdata1   <= id_rdata1;
            ex_rdata2   <= id_rdata2;
            ex_imm      <= id_imm;
            ex_rs       <= id_rs;
            ex_rt       <= id_rt;
            ex_rd       <= id_rd;
            ex_ctrl     <= id_valid ? id_ctrl : '0;
        end
    end

`ifdef ID_EX_PERF_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_cnt <= 32'd0;
        end else if (!flush && !ex_hold && load_use && stall_cnt != 32'hFFFF_FFFF) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - randomized self-checking bench for id_ex_stage against a behavioural EX-slot model
module tb_id_ex_stage;

    localparam int CTRL_W = 12;

    logic              clk;
    logic              rst;
    logic              id_valid;
    logic [31:0]       id_pc, id_rdata1, id_rdata2, id_imm;
    logic [4:0]        id_rs, id_rt, id_rd;
    logic              id_uses_rt, id_memread, id_regwrite;
    logic [CTRL_W-1:0] id_ctrl;
    logic              flush, ex_hold;
    logic              ex_valid, ex_memread, ex_regwrite;
    logic [31:0]       ex_pc, ex_rdata1, ex_rdata2, ex_imm;
    logic [4:0]        ex_rs, ex_rt, ex_rd;
    logic [CTRL_W-1:0] ex_ctrl;
    logic              stall_if_id;
    logic [31:0]       stall_cnt;

    id_ex_stage #(.CTRL_W(CTRL_W)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc(id_pc),
        .id_rdata1(id_rdata1), .id_rdata2(id_rdata2), .id_imm(id_imm),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_uses_rt(id_uses_rt),
        .id_memread(id_memread), .id_regwrite(id_regwrite), .id_ctrl(id_ctrl),
        .flush(flush), .ex_hold(ex_hold),
        .ex_valid(ex_valid), .ex_memread(ex_memread), .ex_regwrite(ex_regwrite),
        .ex_pc(ex_pc), .ex_rdata1(ex_rdata1), .ex_rdata2(ex_rdata2), .ex_imm(ex_imm),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_ctrl(ex_ctrl),
`ifdef ID_EX_PERF_EN
        .stall_cnt(stall_cnt),
`endif
        .stall_if_id(stall_if_id)
    );

`ifndef ID_EX_PERF_EN
    assign stall_cnt = 32'd0;
`endif

    typedef struct packed {
        logic              valid;
        logic              memread;
        logic              regwrite;
        logic [31:0]       pc;
        logic [31:0]       rdata1;
        logic [31:0]       rdata2;
        logic [31:0]       imm;
        logic [4:0]        rs;
        logic [4:0]        rt;
        logic [4:0]        rd;
        logic [CTRL_W-1:0] ctrl;
    } slot_t;

    slot_t       mdl;
    logic [31:0] mdl_cnt;
    int          vectors;
    int          miscompares;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic slot_t actual();
        return {ex_valid, ex_memread, ex_regwrite, ex_pc, ex_rdata1, ex_rdata2,
                ex_imm, ex_rs, ex_rt, ex_rd, ex_ctrl};
    endfunction

    // Hazard as the instruction in ID sees the model's EX slot.
    function automatic logic mdl_load_use();
        if (!(mdl.valid && mdl.memread && mdl.rt != 5'd0 && id_valid)) return 1'b0;
        return (id_rs == mdl.rt) || (id_uses_rt && id_rt == mdl.rt);
    endfunction

    function automatic logic mdl_stall();
        if (!rst) return 1'b0;
        return ex_hold || (mdl_load_use() && !flush);
    endfunction

    task automatic tick();
        slot_t nx;
        logic  bubble;
        bubble = !rst || flush || (!ex_hold && mdl_load_use());
        nx = mdl;
        if (bubble) begin
            nx = '0;
        end else if (!ex_hold) begin
            nx.valid    = id_valid;
            nx.memread  = id_valid && id_memread;
            nx.regwrite = id_valid && id_regwrite;
            nx.pc = id_pc; nx.rdata1 = id_rdata1; nx.rdata2 = id_rdata2; nx.imm = id_imm;
            nx.rs = id_rs; nx.rt = id_rt; nx.rd = id_rd;
            nx.ctrl = id_valid ? id_ctrl : '0;
        end
`ifdef ID_EX_PERF_EN
        if (!rst) mdl_cnt = 0;
        else if (!flush && !ex_hold && mdl_load_use() && mdl_cnt != 32'hFFFF_FFFF) mdl_cnt++;
`endif
        @(posedge clk);
        #1;
        mdl = nx;
    endtask

    task automatic rand_id();
        id_valid    = 1'b1;
        id_pc       = $urandom;
        id_rdata1   = $urandom;
        id_rdata2   = $urandom;
        id_imm      = $urandom;
        id_rs       = 5'($urandom_range(0, 3));
        id_rt       = 5'($urandom_range(0, 3));
        id_rd       = 5'($urandom_range(0, 31));
        id_uses_rt  = 1'($urandom);
        id_memread  = 1'($urandom);
        id_regwrite = 1'($urandom);
        id_ctrl     = CTRL_W'($urandom);
    endtask

    task automatic load_into_ex(input logic [4:0] rt);
        rand_id();
        rst = 1'b1; flush = 1'b0; ex_hold = 1'b0;
        id_memread = 1'b1; id_rt = rt; id_rs = 5'd17; id_uses_rt = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            rand_id();
            rst = 1'b0; flush = 1'($urandom); ex_hold = 1'($urandom);
            #1;
            vectors++;
            if (stall_if_id !== 1'b0) begin
                miscompares++; $display("FAIL reset_stall got %b want 0", stall_if_id);
            end
            tick();
        end
        vectors++;
        if (actual() !== '0) begin
            miscompares++; $display("FAIL reset_outputs got %h want 0", actual());
        end
        vectors++;
        if (stall_cnt !== 32'd0) begin
            miscompares++; $display("FAIL reset_cnt got %0d want 0", stall_cnt);
        end
    endtask

    task automatic test_pass_through();
        rand_id();
        rst = 1'b1; flush = 1'b0; ex_hold = 1'b0;
        id_pc = 32'h0040_0010; id_rdata1 = 32'h1234; id_rs = 5'd3; id_regwrite = 1'b1;
        tick();
        vectors++;
        if (ex_pc !== 32'h0040_0010 || ex_rdata1 !== 32'h1234 || ex_rs !== 5'd3 ||
            ex_regwrite !== 1'b1 || ex_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL pass_through got pc=%h rd1=%h rs=%0d rw=%b v=%b want 00400010 1234 3 1 1",
                     ex_pc, ex_rdata1, ex_rs, ex_regwrite, ex_valid);
        end
        id_memread = 1'b0; id_rs = 5'd0; id_rt = 5'd0;
        #1;
        vectors++;
        if (stall_if_id !== 1'b0) begin
            miscompares++; $display("FAIL pass_stall got %b want 0", stall_if_id);
        end
    endtask

    task automatic test_load_use();
        logic [31:0] cnt0;
        cnt0 = mdl_cnt;
        load_into_ex(5'd8);
        rand_id();
        id_rs = 5'd8; id_memread = 1'b0;
        #1;
        vectors++;
        if (stall_if_id !== 1'b1) begin
            miscompares++; $display("FAIL lu_stall got %b want 1", stall_if_id);
        end
        tick();
        vectors++;
        if (ex_valid !== 1'b0 || ex_memread !== 1'b0 || ex_regwrite !== 1'b0 || ex_ctrl !== '0) begin
            miscompares++; $display("FAIL lu_bubble got v=%b mr=%b rw=%b ctrl=%h want 0 0 0 0",
                                    ex_valid, ex_memread, ex_regwrite, ex_ctrl);
        end
        #1;
        vectors++;
        if (stall_if_id !== 1'b0) begin
            miscompares++; $display("FAIL lu_stall_release got %b want 0", stall_if_id);
        end
        tick();
        vectors++;
        if (ex_valid !== 1'b1 || ex_rs !== 5'd8 || actual() !== mdl) begin
            miscompares++; $display("FAIL lu_capture got %h want %h", actual(), mdl);
        end
`ifdef ID_EX_PERF_EN
        vectors++;
        if (stall_cnt !== cnt0 + 32'd1) begin
            miscompares++; $display("FAIL lu_cnt got %0d want %0d", stall_cnt, cnt0 + 1);
        end
`endif
        load_into_ex(5'd8);
        rand_id();
        id_rs = 5'd5; id_rt = 5'd8; id_uses_rt = 1'b0;
        #1;
        vectors++;
        if (stall_if_id !== 1'b0) begin
            miscompares++; $display("FAIL lu_rt_unused got %b want 0", stall_if_id);
        end
        tick();
    endtask

    task automatic test_zero();
        load_into_ex(5'd0);
        rand_id();
        id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b1;
        #1;
        vectors++;
        if (stall_if_id !== 1'b0) begin
            miscompares++; $display("FAIL zero_stall got %b want 0", stall_if_id);
        end
        tick();
        vectors++;
        if (ex_valid !== 1'b1 || actual() !== mdl) begin
            miscompares++; $display("FAIL zero_capture got %h want %h", actual(), mdl);
        end
    endtask

    task automatic test_hold();
        slot_t       snap;
        logic [31:0] cnt0;
        load_into_ex(5'd8);
        snap = mdl;
        cnt0 = mdl_cnt;
        rand_id();
        id_rs = 5'd8;
        for (int i = 0; i < 3; i++) begin
            ex_hold = 1'b1;
            #1;
            vectors++;
            if (stall_if_id !== 1'b1) begin
                miscompares++; $display("FAIL hold_stall cycle %0d got %b want 1", i, stall_if_id);
            end
            tick();
            vectors++;
            if (actual() !== snap) begin
                miscompares++; $display("FAIL hold_frozen cycle %0d got %h want %h", i, actual(), snap);
            end
        end
        ex_hold = 1'b0;
        #1;
        vectors++;
        if (stall_if_id !== 1'b1) begin
            miscompares++; $display("FAIL hold_release_stall got %b want 1", stall_if_id);
        end
        tick();
        vectors++;
        if (ex_valid !== 1'b0 || stall_if_id !== 1'b0) begin
            miscompares++; $display("FAIL hold_bubble got v=%b stall=%b want 0 0", ex_valid, stall_if_id);
        end
        tick();
        vectors++;
        if (ex_valid !== 1'b1 || ex_rs !== 5'd8) begin
            miscompares++; $display("FAIL hold_capture got v=%b rs=%0d want 1 8", ex_valid, ex_rs);
        end
`ifdef ID_EX_PERF_EN
        vectors++;
        if (stall_cnt !== cnt0 + 32'd1) begin
            miscompares++; $display("FAIL hold_cnt got %0d want %0d", stall_cnt, cnt0 + 1);
        end
`endif
    endtask

    task automatic test_flush();
        logic [31:0] cnt0;
        load_into_ex(5'd8);
        cnt0 = mdl_cnt;
        rand_id();
        id_rs = 5'd8; flush = 1'b1; ex_hold = 1'b1;
        #1;
        vectors++;
        if (stall_if_id !== 1'b1) begin
            miscompares++; $display("FAIL flush_stall got %b want 1", stall_if_id);
        end
        tick();
        vectors++;
        if (actual() !== '0) begin
            miscompares++; $display("FAIL flush_bubble got %h want 0", actual());
        end
        vectors++;
        if (stall_cnt !== cnt0) begin
            miscompares++; $display("FAIL flush_cnt got %0d want %0d", stall_cnt, cnt0);
        end
        flush = 1'b0; ex_hold = 1'b0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            rand_id();
            id_valid = ($urandom_range(0, 7) != 0);
            rst      = ($urandom_range(0, 29) != 0);
            flush    = ($urandom_range(0, 9) == 0);
            ex_hold  = ($urandom_range(0, 5) == 0);
            #1;
            vectors++;
            if (stall_if_id !== mdl_stall()) begin
                miscompares++; $display("FAIL rand_stall step %0d got %b want %b", i, stall_if_id, mdl_stall());
            end
            tick();
            vectors++;
            if (actual() !== mdl || stall_cnt !== mdl_cnt) begin
                miscompares++;
                $display("FAIL rand_state step %0d got %h cnt %0d want %h cnt %0d",
                         i, actual(), stall_cnt, mdl, mdl_cnt);
            end
        end
    endtask

    initial begin
        vectors = 0; miscompares = 0;
        mdl = '0; mdl_cnt = 32'd0;
        rst = 1'b0; flush = 1'b0; ex_hold = 1'b0;
        rand_id();
        test_reset();
        test_pass_through();
        test_load_use();
        test_zero();
        test_hold();
        test_flush();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
